score_bcd_sequencer: RTL



---
 rtl/score_bcd_sequencer_if.sv | 25 ++
 rtl/score_bcd_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/score_bcd_sequencer_if.sv
// Bus between the game-logic score register, the BCD sequencer and the digit renderer.
// frame_start is a one-cycle request with no back-pressure: it is honoured only while busy=0,
// and each accepted conversion is completed by exactly one done pulse.
interface score_bcd_sequencer_if #(
    parameter int SCORE_W = 16,
    parameter int DIGITS  = 5
);
    logic [SCORE_W-1:0]  score;
    logic                frame_start;
    logic [4*DIGITS-1:0] digits_bcd;
    logic [DIGITS-1:0]   blank_mask;
    logic                busy;
    logic                done;
    logic [1:0]          state_dbg;

    modport master (
        output score, frame_start,
        input  digits_bcd, blank_mask, busy, done, state_dbg
    );

    modport slave (
        input  score, frame_start,
        output digits_bcd, blank_mask, busy, done, state_dbg
    );
endinterface

// File: rtl/score_bcd_sequencer.sv
// Once per frame, converts the binary score to BCD with a serial shift-add-3 sequence
// and publishes digits plus a leading-zero blanking mask for the renderer.
module score_bcd_sequencer #(
    parameter int SCORE_W = 16,
    parameter int DIGITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    score_bcd_sequencer_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = SCORE_W + BCD_W;
    localparam int ITER_W = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, LOAD = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [WORK_W-1:0]   work, work_adj, work_step;
    logic [ITER_W-1:0]   iter;
    logic [SCORE_W-1:0]  cap_score, shown_score;
    logic [BCD_W-1:0]    digits_q;
    logic [DIGITS-1:0]   mask_q, mask_nxt;
    logic                done_q;
    logic                start;
    logic                all_zero;

    // An unchanged score would reproduce the shown digits, so the frame is skipped.
    assign start = bus.frame_start && (bus.score != shown_score);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (iter == ITER_W'(SCORE_W - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[SCORE_W + 4*i +: 4] >= 4'd5)
                work_adj[SCORE_W + 4*i +: 4] = work[SCORE_W + 4*i +: 4] + 4'd3;
        end
        work_step = {work_adj[WORK_W-2:0], 1'b0};
    end

    // Bit i blanks digit i when it and every more significant digit are zero; units never blank.
    always_comb begin
        mask_nxt = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (work[SCORE_W + 4*i +: 4] == 4'd0);
            mask_nxt[i] = all_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work        <= '0;
            iter        <= '0;
            cap_score   <= '0;
            shown_score <= '0;
            digits_q    <= '0;
            mask_q      <= {{(DIGITS-1){1'b1}}, 1'b0};
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= {{BCD_W{1'b0}}, bus.score};
                        cap_score <= bus.score;
                        iter      <= '0;
                    end
                end
                CONV: begin
                    work <= work_step;
                    iter <= iter + 1'b1;
                end
                LOAD: begin
                    digits_q    <= work[WORK_W-1:SCORE_W];
                    shown_score <= cap_score;
                    mask_q      <= mask_nxt;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.digits_bcd = digits_q;
    assign bus.blank_mask = mask_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state != IDLE);
    assign bus.state_dbg  = state;
endmodule
